// File: rtl/cdb_result_buffer_pkg.sv
// Shared CDB types: the entry broadcast on the common data bus and the
// per-FU request/grant vectors seen by the arbiter.
package cdb_result_buffer_pkg;

    localparam int CDB_BUF_DEPTH = 4;
    localparam int CDB_TAG_W     = 6;
    localparam int CDB_DATA_W    = 32;
    localparam int NUM_FU        = 4;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } CDB_ENTRY;

    localparam int CDB_ENTRY_W = $bits(CDB_ENTRY);

    typedef logic [NUM_FU-1:0] FU_REQUESTS;
    typedef logic [NUM_FU-1:0] FU_GRANTS;

    function automatic CDB_ENTRY cdb_make_entry(input logic [CDB_TAG_W-1:0]  tag,
                                                input logic [CDB_DATA_W-1:0] data);
        CDB_ENTRY e;
        e.valid = 1'b1;
        e.tag   = tag;
        e.data  = data;
        return e;
    endfunction

endpackage

// File: rtl/cdb_result_buffer.sv
// Per-FU result staging FIFO feeding the CDB arbiter. Requests while holding
// results; presents the head entry in the cycle the registered grant returns.
module cdb_result_buffer
    import cdb_result_buffer_pkg::*;
#(
    parameter int DEPTH = CDB_BUF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [CDB_ENTRY_W-1:0] in_entry,
    output logic                   in_ready,
    output logic                   cdb_req,
    input  logic                   cdb_gnt,
    output logic [CDB_ENTRY_W-1:0] fu_output,
    output logic [CNT_W-1:0]       count
);

    localparam int PTR_W = $clog2(DEPTH);

    CDB_ENTRY               mem_q [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   quiet_q;

    CDB_ENTRY               in_e;
    logic                   enq;
    logic                   pop;

    assign in_e  = CDB_ENTRY'(in_entry);

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never opens a slot for a full buffer.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign enq      = in_valid && in_ready && !flush;
    assign pop      = cdb_gnt && (count_q != '0) && !flush;

    // The entry being consumed under this cycle's grant is not re-requested.
    assign cdb_req   = !flush && (count_q > (cdb_gnt ? CNT_W'(1) : CNT_W'(0)));
    assign fu_output = pop ? CDB_ENTRY_W'(mem_q[head_q]) : '0;
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + 1'b1;
            if (pop) head_d = head_q + 1'b1;
            case ({enq, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            quiet_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            quiet_q <= flush;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i].valid <= 1'b0;
        end else if (enq) begin
            mem_q[tail_q] <= cdb_make_entry(in_e.tag, in_e.data);
        end
    end

    // A grant on an empty buffer is only legal right after flush/reset, when
    // it answers a request made before the squash.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(in_valid && !in_ready && !flush))
                else $warning("cdb_result_buffer: in_valid while full, result dropped");
            assert (!(cdb_gnt && (count_q == '0) && !flush && !quiet_q))
                else $error("cdb_result_buffer: grant received with empty buffer");
        end
    end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Directed bench: stimulus pushes expected CDB entries into a scoreboard that
// a negedge monitor pops whenever the buffer drives fu_output.
module tb_cdb_result_buffer;
    import cdb_result_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   flush;
    logic                   in_valid;
    logic [CDB_ENTRY_W-1:0] in_entry;
    logic                   in_ready;
    logic                   cdb_req;
    logic                   cdb_gnt;
    logic [CDB_ENTRY_W-1:0] fu_output;
    logic [CNT_W-1:0]       count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CDB_ENTRY_W-1:0] exp_q [$];

    cdb_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_entry (in_entry),
        .in_ready (in_ready),
        .cdb_req  (cdb_req),
        .cdb_gnt  (cdb_gnt),
        .fu_output(fu_output),
        .count    (count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: any non-zero broadcast must be the oldest accepted result.
    always @(negedge clock) begin
        if (!reset && fu_output != '0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fu_output_unexpected: got %h, expected no output", fu_output);
            end else begin
                logic [CDB_ENTRY_W-1:0] e;
                e = exp_q.pop_front();
                if (fu_output !== e) begin
                    n_fail++;
                    $display("FAIL fu_output_order: got %h, expected %h", fu_output, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge with all inputs idle.
    task automatic tick();
        @(posedge clock);
        #1;
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        cdb_gnt  = 1'b0;
        in_entry = '0;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic drive_enq(input logic [CDB_TAG_W-1:0] tag, input logic [CDB_DATA_W-1:0] data);
        logic [CDB_ENTRY_W-1:0] e;
        in_valid = 1'b1;
        in_entry = {1'b0, tag, data};
        e = {1'b1, tag, data};
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_gnt = 1'b0; in_entry = '0;

        // reset state
        @(posedge clock); #1;
        settle();
        chk("reset_count",    64'(count),     64'd0);
        chk("reset_in_ready", 64'(in_ready),  64'd1);
        chk("reset_cdb_req",  64'(cdb_req),   64'd0);
        chk("reset_fu_output",64'(fu_output), 64'd0);

        // single result: enqueue, request next cycle, grant the cycle after
        tick(); drive_enq(6'd7, 32'hAB); settle();
        chk("single_req_enq_cycle", 64'(cdb_req), 64'd0);
        tick(); settle();
        chk("single_req", 64'(cdb_req), 64'd1);
        chk("single_cnt", 64'(count),   64'd1);
        tick(); cdb_gnt = 1'b1; settle();
        chk("single_req_on_gnt", 64'(cdb_req), 64'd0);
        tick(); settle();
        chk("single_cnt_after", 64'(count),   64'd0);
        chk("single_req_after", 64'(cdb_req), 64'd0);

        // fill and stall, then a dropped 5th result
        for (int i = 1; i <= 4; i++) begin
            tick(); drive_enq(CDB_TAG_W'(i), 32'h100 + 32'(i)); settle();
        end
        tick(); settle();
        chk("full_cnt",      64'(count),    64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_req",      64'(cdb_req),  64'd1);
        tick(); in_valid = 1'b1; in_entry = {1'b0, 6'd5, 32'h105}; settle();
        tick(); settle();
        chk("full_drop_cnt", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            tick(); cdb_gnt = 1'b1; settle();
            chk($sformatf("drain_req_%0d", i), 64'(cdb_req), (i == 3) ? 64'd0 : 64'd1);
        end
        tick(); settle();
        chk("drain_cnt", 64'(count), 64'd0);

        // lost arbitration: request persists, no output until granted
        tick(); drive_enq(6'd9, 32'h99); settle();
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk($sformatf("lost_req_%0d", i), 64'(cdb_req),   64'd1);
            chk($sformatf("lost_cnt_%0d", i), 64'(count),     64'd1);
            chk($sformatf("lost_out_%0d", i), 64'(fu_output), 64'd0);
        end
        tick(); cdb_gnt = 1'b1; settle();
        tick(); settle();
        chk("lost_cnt_after", 64'(count), 64'd0);

        // concurrent enqueue and pop across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            tick(); drive_enq(CDB_TAG_W'(6'h11 + i), 32'h200 + 32'(i)); settle();
        end
        tick(); cdb_gnt = 1'b1; settle();
        chk("conc_in_ready_full", 64'(in_ready), 64'd0);
        tick(); cdb_gnt = 1'b1; drive_enq(6'h15, 32'h204); settle();
        chk("conc_cnt_3", 64'(count),    64'd3);
        chk("conc_ready", 64'(in_ready), 64'd1);
        tick(); settle();
        chk("conc_cnt_hold", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            tick(); cdb_gnt = 1'b1; settle();
        end
        tick(); settle();
        chk("conc_cnt_empty", 64'(count), 64'd0);

        // flush with a grant pending, then a late grant for a squashed request
        for (int i = 0; i < 3; i++) begin
            tick(); drive_enq(CDB_TAG_W'(6'h21 + i), 32'h300 + 32'(i)); settle();
        end
        tick(); flush = 1'b1; cdb_gnt = 1'b1; in_valid = 1'b1; in_entry = {1'b0, 6'h2F, 32'h3FF};
        exp_q.delete();
        settle();
        chk("flush_out", 64'(fu_output), 64'd0);
        chk("flush_req", 64'(cdb_req),   64'd0);
        tick(); cdb_gnt = 1'b1; settle();
        chk("post_flush_out", 64'(fu_output), 64'd0);
        chk("post_flush_cnt", 64'(count),     64'd0);
        chk("post_flush_req", 64'(cdb_req),   64'd0);

        // reset mid-operation, then recovery
        tick(); drive_enq(6'h31, 32'h400); settle();
        tick(); drive_enq(6'h32, 32'h401); settle();
        tick(); reset = 1'b1; cdb_gnt = 1'b1; exp_q.delete(); settle();
        tick(); settle();
        chk("rst_mid_cnt",   64'(count),     64'd0);
        chk("rst_mid_req",   64'(cdb_req),   64'd0);
        chk("rst_mid_out",   64'(fu_output), 64'd0);
        chk("rst_mid_ready", 64'(in_ready),  64'd1);
        tick(); drive_enq(6'h33, 32'h402); settle();
        tick(); settle();
        tick(); cdb_gnt = 1'b1; settle();
        tick(); settle();
        chk("recover_cnt", 64'(count), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
